// File: rtl/btn_pkg.sv
// Shared types and board defaults for the push-button debouncer.
// Default timing assumes the 100 MHz board clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_e;

  // 10 ms settle time
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  // 0.5 s long-press threshold
  localparam int unsigned LONG_CYCLES_DEF = 50000000;
  localparam int unsigned CNT_W_DEF = 26;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce FSM, hold counter.
// All outputs are registered straight from next-state logic.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  // hcnt parks one past the threshold so long fires once
  localparam logic [CNT_W-1:0] LONG_SAT =
    CNT_W'(LONG_CYCLES);

  logic sync1_q, sync2_q, btn_s;
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic pressed_q, pressed_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;

  assign btn_s = sync2_q;

  // bring the raw pin into the clk domain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // debounce transitions and event strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (btn_s) begin
          state_d = ARMING;
          cnt_d   = ONE;
        end
      end
      ARMING: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASING;
          cnt_d   = ONE;
        end else begin
          if (hcnt_q == LONG_LAST) long_d = 1'b1;
          if (hcnt_q != LONG_SAT) hcnt_d = hcnt_q + ONE;
        end
      end
      RELEASING: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          hcnt_d    = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    pressed_d = (state_d == PRESSED) ||
                (state_d == RELEASING);
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_debounce.sv
// Debounced level and press/release/long events for
// N_BUTTONS independent raw push-buttons.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_BUTTONS = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_pulse
);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i(clk),
      .rst_i(rst),
      .btn_i(btn[g]),
      .pressed_o(pressed[g]),
      .press_o(press_pulse[g]),
      .release_o(release_pulse[g]),
      .long_o(long_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce, D=4, L=16, 4 channels.
// Edge 0 is the edge right before btn is changed.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] long_pulse;

  int n_vec = 0;
  int n_bad = 0;

  button_debounce #(
    .N_BUTTONS(4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {pressed, press_pulse,
            release_pulse, long_pulse};
  endfunction

  initial begin
    // reset
    #1 rst = 1'b1;
    #1 chk("rst_async", all_outs(), 16'h0);
    tick();
    tick();
    chk("rst_hold", all_outs(), 16'h0);
    #3 rst = 1'b0;
    tick();
    tick();
    chk("idle", all_outs(), 16'h0);

    // clean press on btn[0]
    btn = 4'b0001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("t1_pp", press_pulse,
          (e == 6) ? 4'b0001 : 4'b0000);
      chk("t1_lvl", pressed,
          (e >= 6) ? 4'b0001 : 4'b0000);
    end

    // release glitch of two cycles
    btn = 4'b0000;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 2) btn = 4'b0001;
      chk("t4_pp", press_pulse, 4'b0000);
      chk("t4_rp", release_pulse, 4'b0000);
      chk("t4_lvl", pressed, 4'b0001);
    end

    // real release
    btn = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t4_rel", release_pulse,
          (e == 6) ? 4'b0001 : 4'b0000);
      chk("t4_rlvl", pressed,
          (e < 6) ? 4'b0001 : 4'b0000);
    end

    // bounce on btn[1]
    begin
      logic [6:0] pat;
      pat = 7'b1011010;
      for (int e = 0; e < 15; e++) begin
        btn[1] = (e < 7) ? pat[6 - e] : 1'b0;
        tick();
        chk("t2_pp", press_pulse, 4'b0000);
        chk("t2_lvl", pressed, 4'b0000);
      end
    end

    // long hold on btn[2]
    btn = 4'b0100;
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk("t3_pp", press_pulse,
          (e == 6) ? 4'b0100 : 4'b0000);
      chk("t3_lp", long_pulse,
          (e == 22) ? 4'b0100 : 4'b0000);
      chk("t3_lvl", pressed,
          (e >= 6) ? 4'b0100 : 4'b0000);
    end
    btn = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t3_rp", release_pulse,
          (e == 6) ? 4'b0100 : 4'b0000);
      chk("t3_rlvl", pressed,
          (e < 6) ? 4'b0100 : 4'b0000);
    end

    // reset mid-ARMING
    btn = 4'b0001;
    repeat (4) tick();
    #3 rst = 1'b1;
    #1 chk("t5_arm", all_outs(), 16'h0);
    tick();
    chk("t5_arm2", all_outs(), 16'h0);
    #3 rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t5_pp1", press_pulse,
          (e == 6) ? 4'b0001 : 4'b0000);
      chk("t5_lvl1", pressed,
          (e >= 6) ? 4'b0001 : 4'b0000);
    end

    // reset mid-PRESSED
    #3 rst = 1'b1;
    #1 chk("t5_prs", all_outs(), 16'h0);
    tick();
    chk("t5_prs2", all_outs(), 16'h0);
    #3 rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t5_pp2", press_pulse,
          (e == 6) ? 4'b0001 : 4'b0000);
      chk("t5_rp2", release_pulse, 4'b0000);
    end

    // all channels together
    btn = 4'b0000;
    repeat (10) tick();
    chk("t6_idle", all_outs(), 16'h0);
    btn = 4'b1111;
    for (int e = 1; e <= 24; e++) begin
      tick();
      chk("t6_pp", press_pulse,
          (e == 6) ? 4'b1111 : 4'b0000);
      chk("t6_lp", long_pulse,
          (e == 22) ? 4'b1111 : 4'b0000);
    end
    btn = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t6_rp", release_pulse,
          (e == 6) ? 4'b1111 : 4'b0000);
    end
    chk("t6_end", all_outs(), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
